// File: rtl/bsg_adder_multiword_serial.sv
// Serial multi-word adder: streams wide operands one width_p chunk per beat, LS chunk first,
// through a carry-select adder while owning the inter-chunk carry chain.
module bsg_adder_multiword_serial #(
  parameter int unsigned width_p = 32,
  parameter int unsigned words_p = 4
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               v_i,
  input  logic [width_p-1:0] a_i,
  input  logic [width_p-1:0] b_i,
  input  logic               c_i,
  output logic               ready_o,
  output logic               v_o,
  output logic [width_p-1:0] sum_o,
  output logic               c_o,
  output logic               last_o,
  input  logic               ready_i
);

  localparam int unsigned CntW = (words_p > 1) ? $clog2(words_p) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(words_p - 1);

  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic               v_q, v_d;
  logic [width_p-1:0] sum_q, sum_d;
  logic               c_q, c_d;
  logic               last_q, last_d;

  logic               accept;
  logic               cin;
  logic [width_p:0]   r;

  assign ready_o = ~v_q | ready_i;
  assign accept  = v_i & ready_o;
  // The caller's carry-in only enters on the first chunk; later chunks chain internally.
  assign cin     = (cnt_q == '0) ? c_i : carry_q;

  generate
    if (width_p < 2) begin : g_narrow
      assign r = {1'b0, a_i} + {1'b0, b_i} + {{width_p{1'b0}}, cin};
    end else begin : g_csel
      localparam int unsigned LoW = width_p / 2;
      localparam int unsigned HiW = width_p - LoW;

      logic [LoW:0] lo;
      logic [HiW:0] hi0, hi1;

      // Upper half is precomputed for both carry values; the low-half carry picks one.
      assign lo  = {1'b0, a_i[LoW-1:0]} + {1'b0, b_i[LoW-1:0]} + {{LoW{1'b0}}, cin};
      assign hi0 = {1'b0, a_i[width_p-1:LoW]} + {1'b0, b_i[width_p-1:LoW]};
      assign hi1 = hi0 + {{HiW{1'b0}}, 1'b1};
      assign r   = {(lo[LoW] ? hi1 : hi0), lo[LoW-1:0]};
    end
  endgenerate

  always_comb begin
    cnt_d   = cnt_q;
    carry_d = carry_q;
    v_d     = v_q;
    sum_d   = sum_q;
    c_d     = c_q;
    last_d  = last_q;
    if (accept) begin
      sum_d   = r[width_p-1:0];
      c_d     = r[width_p];
      carry_d = r[width_p];
      last_d  = (cnt_q == LastCnt);
      v_d     = 1'b1;
      cnt_d   = (cnt_q == LastCnt) ? '0 : cnt_q + CntW'(1);
    end else if (ready_i) begin
      v_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt_q   <= '0;
      carry_q <= 1'b0;
      v_q     <= 1'b0;
      sum_q   <= '0;
      c_q     <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      v_q     <= v_d;
      sum_q   <= sum_d;
      c_q     <= c_d;
      last_q  <= last_d;
    end
  end

  assign v_o    = v_q;
  assign sum_o  = sum_q;
  assign c_o    = c_q;
  assign last_o = last_q;

endmodule

// File: tb/tb_bsg_adder_multiword_serial.sv
// Scoreboard bench: instance 0 is 8x2 (directed cases), instance 1 is 8x3 (randomized).
module tb_bsg_adder_multiword_serial;

  typedef struct packed {
    logic [7:0] sum;
    logic       c;
    logic       last;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       v_s[2], c_s[2], rdy_i[2], rdy_o[2], vo[2], co[2], lo[2];
  logic [7:0] a_s[2], b_s[2], so[2];

  int   rmode[2];          // 0: ready_i high, 1: random, 2: ready_i low
  exp_t exp_cur[2];
  exp_t held[2];
  logic hold_prev[2], acc_prev[2];
  exp_t q0[$], q1[$];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  bsg_adder_multiword_serial #(.width_p(8), .words_p(2)) u_dut_w2 (
    .clk_i(clk), .reset_n_i(rst_n), .v_i(v_s[0]), .a_i(a_s[0]), .b_i(b_s[0]), .c_i(c_s[0]),
    .ready_o(rdy_o[0]), .v_o(vo[0]), .sum_o(so[0]), .c_o(co[0]), .last_o(lo[0]),
    .ready_i(rdy_i[0])
  );

  bsg_adder_multiword_serial #(.width_p(8), .words_p(3)) u_dut_w3 (
    .clk_i(clk), .reset_n_i(rst_n), .v_i(v_s[1]), .a_i(a_s[1]), .b_i(b_s[1]), .c_i(c_s[1]),
    .ready_o(rdy_o[1]), .v_o(vo[1]), .sum_o(so[1]), .c_o(co[1]), .last_o(lo[1]),
    .ready_i(rdy_i[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int qsize(input int idx);
    return (idx == 0) ? q0.size() : q1.size();
  endfunction

  function automatic void qpush(input int idx, input exp_t e);
    if (idx == 0) q0.push_back(e);
    else q1.push_back(e);
  endfunction

  function automatic exp_t qpop(input int idx);
    if (idx == 0) return q0.pop_front();
    return q1.pop_front();
  endfunction

  // Drives ready_i at the falling edge, then samples what the next rising edge will act on.
  task automatic mon_step(input int idx);
    exp_t e;
    case (rmode[idx])
      0:       rdy_i[idx] = 1'b1;
      1:       rdy_i[idx] = 1'($urandom_range(0, 1));
      default: rdy_i[idx] = 1'b0;
    endcase
    #1;
    if (!rst_n) begin
      hold_prev[idx] = 1'b0;
      acc_prev[idx]  = 1'b0;
      return;
    end
    check($sformatf("ready_o%0d", idx), 32'(rdy_o[idx]), 32'(!vo[idx] || rdy_i[idx]));
    if (hold_prev[idx])
      check($sformatf("hold%0d", idx), {vo[idx], so[idx], co[idx], lo[idx]}, {1'b1, held[idx]});
    if (acc_prev[idx]) check($sformatf("latency%0d", idx), 32'(vo[idx]), 32'd1);
    if (vo[idx] && rdy_i[idx]) begin
      if (qsize(idx) == 0) begin
        check($sformatf("spurious_v_o%0d", idx), 32'(vo[idx]), 32'd0);
      end else begin
        e = qpop(idx);
        check($sformatf("beat%0d", idx), {so[idx], co[idx], lo[idx]}, e);
      end
    end
    hold_prev[idx] = vo[idx] && !rdy_i[idx];
    held[idx]      = {so[idx], co[idx], lo[idx]};
    acc_prev[idx]  = v_s[idx] && rdy_o[idx];
    if (acc_prev[idx]) qpush(idx, exp_cur[idx]);
  endtask

  always @(negedge clk) mon_step(0);
  always @(negedge clk) mon_step(1);

  // Entered and left at a falling edge; v_i is left high so ops can run back to back.
  task automatic send_op(input int idx, input int nw, input int nsend, input logic [23:0] a,
                         input logic [23:0] b, input logic cin, input logic ci_oth,
                         input bit gaps);
    logic [32:0] s, mask;
    exp_t        e;
    int          t, g;
    for (int k = 0; k < nsend; k++) begin
      if (gaps) begin
        g = $urandom_range(0, 2);
        if (g > 0) begin
          v_s[idx] = 1'b0;
          repeat (g) @(negedge clk);
        end
      end
      mask   = (33'h1 << (8 * (k + 1))) - 33'h1;
      s      = ({9'b0, a} & mask) + ({9'b0, b} & mask) + {32'b0, cin};
      e.sum  = s[8*k +: 8];
      e.c    = s[8*(k+1)];
      e.last = (k == nw - 1);
      v_s[idx]     = 1'b1;
      a_s[idx]     = a[8*k +: 8];
      b_s[idx]     = b[8*k +: 8];
      c_s[idx]     = (k == 0) ? cin : ci_oth;
      exp_cur[idx] = e;
      t = 0;
      forever begin
        #1;
        if (rdy_o[idx]) break;
        @(negedge clk);
        t++;
        if (t > 200) begin
          check("accept_timeout", 32'(t), 32'd0);
          break;
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic drain(input int idx);
    int t = 0;
    while ((vo[idx] || qsize(idx) != 0) && t < 300) begin
      @(negedge clk);
      t++;
    end
    check($sformatf("drain%0d", idx), 32'(qsize(idx)), 32'd0);
  endtask

  // Called just after a falling edge; reset hits asynchronously between edges.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++)
      check($sformatf("reset_out%0d", i), {vo[i], so[i], co[i], lo[i]}, 32'd0);
    q0.delete();
    q1.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) check($sformatf("reset_ready%0d", i), 32'(rdy_o[i]), 32'd1);
    @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      v_s[i] = 1'b0; a_s[i] = '0; b_s[i] = '0; c_s[i] = 1'b0; rmode[i] = 0;
    end
    repeat (2) @(negedge clk);
    #1;
    for (int i = 0; i < 2; i++)
      check($sformatf("in_reset%0d", i), {vo[i], so[i], co[i], lo[i]}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) check($sformatf("ready_after_reset%0d", i), 32'(rdy_o[i]), 32'd1);
    @(negedge clk);

    // Carry chain, full overflow then a clean op back to back, carry-in only on chunk 0.
    send_op(0, 2, 2, 24'h01FF, 24'h0001, 1'b0, 1'b1, 1'b0);
    send_op(0, 2, 2, 24'hFFFF, 24'h0001, 1'b0, 1'b0, 1'b0);
    send_op(0, 2, 2, 24'h0000, 24'h0000, 1'b0, 1'b0, 1'b0);
    send_op(0, 2, 2, 24'h0000, 24'h0000, 1'b1, 1'b1, 1'b0);
    v_s[0] = 1'b0;
    drain(0);

    // Backpressure: output stalls with input pending, then released.
    rmode[0] = 2;
    fork
      begin
        send_op(0, 2, 2, 24'h1234, 24'h5678, 1'b0, 1'b1, 1'b0);
        send_op(0, 2, 2, 24'hABCD, 24'h9876, 1'b1, 1'b0, 1'b0);
      end
      begin
        repeat (5) @(negedge clk);
        #2 rmode[0] = 0;
      end
    join
    v_s[0] = 1'b0;
    drain(0);

    // Reset mid-stream with v_o held high.
    rmode[0] = 2;
    send_op(0, 2, 1, 24'h00FF, 24'h00FF, 1'b1, 1'b0, 1'b0);
    v_s[0] = 1'b0;
    #1 check("pre_reset_v_o", 32'(vo[0]), 32'd1);
    do_reset();
    rmode[0] = 0;
    send_op(0, 2, 2, 24'h80FF, 24'h8001, 1'b0, 1'b1, 1'b0);
    v_s[0] = 1'b0;
    drain(0);

    // Randomized 8x3 with random ready_i and gaps; abandon one op by reset after chunk 1.
    rmode[1] = 1;
    for (int n = 0; n < 25; n++)
      send_op(1, 3, 3, (n % 5 == 0) ? 24'hFFFFFF : 24'($urandom), 24'($urandom),
              1'($urandom), 1'($urandom), 1'b1);
    send_op(1, 3, 2, 24'hFFFFFF, 24'h000001, 1'b1, 1'b0, 1'b0);
    v_s[1] = 1'b0;
    do_reset();
    send_op(1, 3, 3, 24'h00FFFF, 24'h000000, 1'b1, 1'b0, 1'b0);
    for (int n = 0; n < 15; n++)
      send_op(1, 3, 3, 24'($urandom), 24'($urandom), 1'($urandom), 1'($urandom), 1'b1);
    v_s[1] = 1'b0;
    rmode[1] = 0;
    drain(1);
    drain(0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bsg_adder_multiword_serial.md
Name: bsg_adder_multiword_serial

Overview:
- Serial multi-word adder that streams wide operands through the team's carry-select adder, one width_p chunk per beat, least-significant chunk first.
- Owns the inter-chunk carry chain. The carry-out of each chunk is fed back as c_i of the next chunk. The caller's carry-in is applied on the first chunk only.
- Sits directly upstream of the carry-select adder: it drives that adder's a_i/b_i/c_i and registers its width_p+1-bit result.
- Used where words_p*width_p-bit additions are too wide for a single-cycle adder.

Parameters:
- width_p, 32, chunk width in bits; passed to the internal carry-select adder.
- words_p, 4, chunks per operation; must be >= 1.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  reset; asynchronous, active-low.
- v_i  in  1  input chunk valid.
- a_i  in  width_p  operand A chunk.
- b_i  in  width_p  operand B chunk.
- c_i  in  1  operation carry-in; sampled only with the first chunk of an operation.
- ready_o  out  1  block can accept a chunk this cycle.
- v_o  out  1  sum chunk valid.
- sum_o  out  width_p  sum chunk.
- c_o  out  1  carry-out of the chunk currently on sum_o; the final carry when last_o=1.
- last_o  out  1  sum_o is the most-significant chunk of the operation.
- ready_i  in  1  downstream accepts the output chunk.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low. While reset_n_i=0, all state clears immediately:
  - v_o=0, sum_o=0, c_o=0, last_o=0
  - chunk counter cnt_r=0, carry register carry_r=0
  - ready_o=1 as soon as reset deasserts.
- Handshakes: input accepted when v_i & ready_o; output consumed when v_o & ready_i.
- ready_o = ~v_o | ready_i. Single output register, bubble-free, combinational ready path from ready_i.
- Carry selection: cin = (cnt_r==0) ? c_i : carry_r. Feed {a_i, b_i, cin} to the carry-select adder, producing a width_p+1-bit result r.
- On accept, in the same edge:
  - sum_o <= r[width_p-1:0]
  - c_o <= r[width_p]
  - carry_r <= r[width_p]
  - last_o <= (cnt_r==words_p-1)
  - v_o <= 1
  - cnt_r <= (cnt_r==words_p-1) ? 0 : cnt_r+1
- Latency: 1 cycle from accept to v_o. Throughput: 1 chunk/cycle with ready_i held high.
- Output consumed with no new accept: v_o <= 0. sum_o/c_o/last_o hold their values (don't-care while v_o=0).
- Simultaneous consume and accept: the output register loads the new chunk and v_o stays 1.
- Backpressure: when v_o=1 & ready_i=0:
  - ready_o=0 and no input is accepted.
  - sum_o/c_o/last_o/v_o are held stable.
  - cnt_r and carry_r do not change.
- Operation boundary:
  - After the chunk with cnt_r==words_p-1 is accepted, cnt_r wraps to 0. The next chunk uses c_i; carry_r from the previous operation is ignored.
  - Back-to-back operations run with no idle cycle.
- words_p==1: every chunk is first and last. cin=c_i always; last_o=1 on every output.
- No abort port. The only way to abandon a partial operation is reset; after reset the next chunk is treated as first.
- Arithmetic is unsigned modulo 2^(words_p*width_p). The overflow indication is c_o on the last_o beat.
- v_i=0 with ready_o=1: no state change except the output drain described above.

Test Plan:
- Reset: assert reset_n_i=0 mid-stream with v_o=1 -> v_o/c_o/last_o/sum_o drop to 0 without a clock edge. After release, ready_o=1.
- Carry chain (width_p=8, words_p=2): 0x01FF+0x0001, c_i=0, chunks (FF,01) then (01,00), ready_i=1 -> beat0 sum 0x00 c_o=1 last_o=0; beat1 sum 0x02 c_o=0 last_o=1; each 1 cycle after accept.
- Full overflow: 0xFFFF+0x0001, c_i=0 -> beats 0x00 (c_o=1), 0x00 (c_o=1, last_o=1).
- Carry-in: 0x0000+0x0000 with c_i=1 -> beats 0x01 (c_o=0), 0x00 (last_o=1). The c_i value presented with chunk1 (set to 1) is ignored.
- Backpressure: hold ready_i=0 for 3 cycles while v_o=1 and v_i=1 -> ready_o=0, sum_o stable, no chunk lost. On ready_i=1, results stream at 1/cycle and match a reference model.
- Back-to-back isolation: 0xFFFF+0x0001 immediately followed by 0x0000+0x0000 with c_i=0, no gap -> second op beats 0x00, 0x00, final c_o=0; no carry leaks from op1.
- Randomized check (width_p=8, words_p=3): random v_i/ready_i and random operands vs a scoreboard; reset_n_i pulsed after chunk1 -> the next chunk restarts at cnt 0 using c_i.
